// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// General-purpose register file for the minisys-1A pipeline with a per-register
// pending-write scoreboard for long-latency producers (load, mul/div).
// Register 0 is hardwired to zero: reads return 0, writes and issues to it are
// ignored.
//
// Build option:
//   REGFILE_BYPASS_EN  defined   -> write-through forwarding on every read port;
//                                   rd_busy drops in the cycle the last pending
//                                   write retires.
//                      undefined -> reads always return stored contents; new
//                                   data (and the busy release) is visible the
//                                   cycle after the write.
//
// Parameters:
//   DATA_W       register width
//   ADDR_W       address width, depth = 2**ADDR_W
//   NUM_RD       number of combinational read ports (1..4)
//   PEND_W       pending-counter width, saturates at 2**PEND_W-1
//   RESET_INDEX  1: register i resets to i, 0: all registers reset to 0
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset, dominates all other inputs
//   rd_addr      packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_use       per-port operand-consumed flag
//   rd_data      packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy      per-port "source has an outstanding write"
//   stall        OR over ports of rd_use & rd_busy
//   wr_en        writeback strobe
//   wr_addr      writeback destination
//   wr_data      writeback data
//   issue_en     long-latency producer issued towards issue_addr
//   issue_addr   destination of the issued producer
//   issue_ready  pending counter of issue_addr is not saturated
//   sb_err       sticky scoreboard error (retire with nothing pending on a
//                tracked register, or issue while not ready)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_RD      = 2,
  parameter int PEND_W      = 2,
  parameter int RESET_INDEX = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  output logic                     sb_err
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [PEND_W-1:0] cnt  [DEPTH];
  // Set on the first accepted issue to a register; only tracked registers
  // flag an error when a write retires with nothing pending, so plain ALU
  // writebacks to never-issued registers stay silent.
  logic [DEPTH-1:0]  tracked;

  logic issue_nz;
  logic issue_sat;
  logic issue_acc;
  logic issue_rej;
  logic wr_nz;
  logic same_reg;
  logic wr_ret;
  logic wr_err;

  // ---------------------------------------------------------------------------
  // Scoreboard decode
  // ---------------------------------------------------------------------------
  assign issue_nz    = issue_en && (issue_addr != '0);
  assign issue_sat   = (cnt[issue_addr] == CNT_MAX);
  assign issue_ready = (issue_addr == '0) || !issue_sat;
  assign issue_acc   = issue_nz && !issue_sat;
  assign issue_rej   = issue_nz && issue_sat;

  assign wr_nz    = wr_en && (wr_addr != '0);
  // An accepted issue and a retiring write to the same register cancel out.
  assign same_reg = issue_acc && wr_nz && (wr_addr == issue_addr);
  assign wr_ret   = wr_nz && !same_reg;
  assign wr_err   = wr_ret && (cnt[wr_addr] == '0) && tracked[wr_addr];

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (RESET_INDEX != 0 && i != 0) ? DATA_W'(i) : '0;
        cnt[i]  <= '0;
      end
      tracked <= '0;
      sb_err  <= 1'b0;
    end else begin
      if (wr_nz) begin
        regs[wr_addr] <= wr_data;
      end
      if (issue_acc) begin
        tracked[issue_addr] <= 1'b1;
        if (!same_reg) begin
          cnt[issue_addr] <= cnt[issue_addr] + CNT_ONE;
        end
      end
      // same_reg excludes wr_ret, so this never collides with the increment.
      if (wr_ret && (cnt[wr_addr] != '0)) begin
        cnt[wr_addr] <= cnt[wr_addr] - CNT_ONE;
      end
      if (issue_rej || wr_err) begin
        sb_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              pend;

    assign ra   = rd_addr[k*ADDR_W +: ADDR_W];
    assign pend = (ra != '0) && (cnt[ra] != '0);

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_nz && (wr_addr == ra);

    assign rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                         hit        ? wr_data : regs[ra];
    // The last outstanding write is being forwarded right now, so the
    // consumer can proceed this cycle.
    assign rd_busy[k] = pend && !(hit && (cnt[ra] == CNT_ONE));
`else
    assign rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : regs[ra];
    assign rd_busy[k] = pend;
`endif
  end

  assign stall = |(rd_use & rd_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        sb_err;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard dut (
    .clock      (clock),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_use     (rd_use),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_ready(issue_ready),
    .sb_err     (sb_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: plain arrays and integer counts.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_trk  [32];
  bit          m_err;

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(logic [4:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && wr_en && wr_addr == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'(i);
        m_cnt[i]  = 0;
        m_trk[i]  = 0;
      end
      m_err = 0;
    end else begin
      bit acc;
      acc = 0;
      if (issue_en && issue_addr != 0) begin
        if (m_cnt[issue_addr] < 3) acc = 1;
        else m_err = 1;
      end
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        if (!(acc && issue_addr == wr_addr)) begin
          if (m_cnt[wr_addr] > 0) m_cnt[wr_addr]--;
          else if (m_trk[wr_addr]) m_err = 1;
        end
      end
      if (acc) begin
        m_trk[issue_addr] = 1;
        if (!(wr_en && wr_addr == issue_addr)) m_cnt[issue_addr]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(logic we, logic [4:0] wa, logic [31:0] wd, logic ie,
                        logic [4:0] ia, logic [4:0] a0, logic [4:0] a1, logic [1:0] u);
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia;
    rd_addr = {a1, a0}; rd_use = u;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  u;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        stl;
    logic        rdy;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic ie,
                              logic [4:0] ia, logic [4:0] a0, logic [4:0] a1, logic [1:0] u,
                              logic [31:0] d0, logic [31:0] d1, logic [1:0] busy,
                              logic stl, logic rdy, logic err);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
    v.a0 = a0; v.a1 = a1; v.u = u;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.stl = stl; v.rdy = rdy; v.err = err;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    reset = 1'b0;
    idle();

    //            we wa  wd            ie ia  a0  a1  use    d0                     d1                     busy                 stl             rdy  err
    tbl[0]  = mk(0, 0,  32'h0,        0, 0,  5,  17, 2'b00, 32'd5,                 32'd17,                2'b00,               0,              1,   0);
    tbl[1]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  2'b11, 32'd0,                 32'd0,                 2'b00,               0,              1,   0);
    tbl[2]  = mk(1, 0,  32'hDEADBEEF, 1, 0,  0,  0,  2'b11, 32'd0,                 32'd0,                 2'b00,               0,              1,   0);
    tbl[3]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  2'b11, 32'd0,                 32'd0,                 2'b00,               0,              1,   0);
    tbl[4]  = mk(0, 0,  32'h0,        1, 8,  8,  1,  2'b01, 32'd8,                 32'd1,                 2'b00,               0,              1,   0);
    tbl[5]  = mk(0, 0,  32'h0,        0, 8,  8,  1,  2'b01, 32'd8,                 32'd1,                 2'b01,               1,              1,   0);
    tbl[6]  = mk(1, 8,  32'h1234,     0, 8,  8,  8,  2'b01, BYP ? 32'h1234 : 32'd8, BYP ? 32'h1234 : 32'd8, BYP ? 2'b00 : 2'b11, BYP ? 1'b0 : 1'b1, 1, 0);
    tbl[7]  = mk(0, 0,  32'h0,        0, 8,  8,  8,  2'b11, 32'h1234,              32'h1234,              2'b00,               0,              1,   0);
    tbl[8]  = mk(0, 0,  32'h0,        1, 3,  3,  0,  2'b00, 32'd3,                 32'd0,                 2'b00,               0,              1,   0);
    tbl[9]  = mk(0, 0,  32'h0,        1, 3,  3,  0,  2'b00, 32'd3,                 32'd0,                 2'b01,               0,              1,   0);
    tbl[10] = mk(0, 0,  32'h0,        1, 3,  3,  0,  2'b00, 32'd3,                 32'd0,                 2'b01,               0,              1,   0);
    tbl[11] = mk(0, 0,  32'h0,        1, 3,  3,  0,  2'b00, 32'd3,                 32'd0,                 2'b01,               0,              0,   0);
    tbl[12] = mk(0, 0,  32'h0,        0, 3,  3,  0,  2'b01, 32'd3,                 32'd0,                 2'b01,               1,              0,   1);
    tbl[13] = mk(1, 3,  32'hA1,       0, 3,  3,  3,  2'b11, BYP ? 32'hA1 : 32'd3,   BYP ? 32'hA1 : 32'd3,   2'b11,               1,              0,   1);
    tbl[14] = mk(1, 3,  32'hA2,       0, 3,  3,  3,  2'b11, BYP ? 32'hA2 : 32'hA1,  BYP ? 32'hA2 : 32'hA1,  2'b11,               1,              1,   1);
    tbl[15] = mk(1, 3,  32'hA3,       0, 3,  3,  3,  2'b11, BYP ? 32'hA3 : 32'hA2,  BYP ? 32'hA3 : 32'hA2,  BYP ? 2'b00 : 2'b11, BYP ? 1'b0 : 1'b1, 1, 1);
    tbl[16] = mk(0, 0,  32'h0,        0, 3,  3,  3,  2'b11, 32'hA3,                32'hA3,                2'b00,               0,              1,   1);

    @(posedge clock);
    #1;
    do_reset();

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia,
             tbl[i].a0, tbl[i].a1, tbl[i].u);
      @(negedge clock);
      chk($sformatf("tbl%0d.d0", i), rd_data[31:0], tbl[i].d0);
      chk($sformatf("tbl%0d.d1", i), rd_data[63:32], tbl[i].d1);
      chk($sformatf("tbl%0d.busy", i), 32'(rd_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tbl[i].stl));
      chk($sformatf("tbl%0d.ready", i), 32'(issue_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.err", i), 32'(sb_err), 32'(tbl[i].err));
      tick();
    end

    // Same-cycle issue and write on a register with one write pending.
    do_reset();
    set_in(0, 0, 0, 1, 9, 9, 0, 2'b00);
    tick();
    set_in(1, 9, 32'h9999, 1, 9, 9, 0, 2'b01);
    @(negedge clock);
    chk("same.ready", 32'(issue_ready), 32'd1);
    tick();
    set_in(0, 0, 0, 0, 9, 9, 0, 2'b01);
    @(negedge clock);
    chk("same.busy", 32'(rd_busy[0]), 32'd1);
    chk("same.data", rd_data[31:0], 32'h9999);
    chk("same.stall", 32'(stall), 32'd1);
    tick();
    set_in(1, 9, 32'h5, 0, 0, 9, 0, 2'b01);
    tick();
    set_in(0, 0, 0, 0, 0, 9, 0, 2'b01);
    @(negedge clock);
    chk("same.retired_busy", 32'(rd_busy[0]), 32'd0);
    chk("same.retired_err", 32'(sb_err), 32'd0);
    chk("same.retired_data", rd_data[31:0], 32'h5);
    tick();

    // Reset in the middle of outstanding writes.
    set_in(0, 0, 0, 1, 4, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 1, 6, 0, 0, 2'b00);
    tick();
    do_reset();
    set_in(0, 0, 0, 0, 4, 4, 6, 2'b11);
    @(negedge clock);
    chk("rst.busy", 32'(rd_busy), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.d4", rd_data[31:0], 32'd4);
    chk("rst.d6", rd_data[63:32], 32'd6);
    chk("rst.err", 32'(sb_err), 32'd0);
    tick();
    // Untracked register: a write with nothing pending is a plain writeback.
    set_in(1, 4, 32'h44, 0, 0, 0, 0, 2'b00);
    tick();
    idle();
    @(negedge clock);
    chk("untracked.err", 32'(sb_err), 32'd0);
    tick();
    // Tracked register: a second retire with nothing pending is an error.
    set_in(0, 0, 0, 1, 10, 0, 0, 2'b00);
    tick();
    set_in(1, 10, 32'h1, 0, 0, 0, 0, 2'b00);
    tick();
    idle();
    @(negedge clock);
    chk("tracked.err0", 32'(sb_err), 32'd0);
    set_in(1, 10, 32'h2, 0, 0, 0, 0, 2'b00);
    tick();
    idle();
    @(negedge clock);
    chk("tracked.err1", 32'(sb_err), 32'd1);
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      @(negedge clock);
      chk("rnd.d0", rd_data[31:0], m_read(rd_addr[4:0]));
      chk("rnd.d1", rd_data[63:32], m_read(rd_addr[9:5]));
      chk("rnd.busy", 32'(rd_busy), 32'({m_busy(rd_addr[9:5]), m_busy(rd_addr[4:0])}));
      chk("rnd.stall", 32'(stall),
          32'((rd_use[0] & m_busy(rd_addr[4:0])) | (rd_use[1] & m_busy(rd_addr[9:5]))));
      chk("rnd.ready", 32'(issue_ready), 32'(issue_addr == 0 || m_cnt[issue_addr] < 3));
      chk("rnd.err", 32'(sb_err), 32'(m_err));
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the minisys-1A pipeline. It generalises the decode-stage register array to configurable width, depth and read-port count, with register 0 hardwired to zero. It adds a per-register pending-write scoreboard for long-latency producers (load, mul/div), which generates per-port busy flags and a decode stall. An optional write-through bypass is available.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of combinational read ports (1..4)
PEND_W, 2, pending-counter width; at most 2**PEND_W-1 outstanding writes per register
RESET_INDEX, 1, 1: register i resets to i (zero-extended); 0: all registers reset to 0

Ports:
clock  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_use  input  NUM_RD  port k's operand is actually consumed this cycle
rd_data  output  NUM_RD*DATA_W  read data, port k uses bits [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  port k's source has an outstanding write
stall  output  1  OR over k of (rd_use[k] & rd_busy[k])
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback data
issue_en  input  1  a long-latency producer targeting issue_addr is issued
issue_addr  input  ADDR_W  destination of the issued producer
issue_ready  output  1  the pending counter of issue_addr is not saturated
sb_err  output  1  sticky flag: write retired to a register whose count is 0, or issue attempted while not ready

Behaviour:
- Reset (synchronous, has priority over all other inputs):
  - regs[i] <= RESET_INDEX ? i : 0; regs[0] <= 0 always.
  - All pending counters <= 0; sb_err <= 0.
  - A reset asserted mid-operation discards all outstanding pending writes.
- Register 0:
  - Reads always return 0.
  - Writes are ignored; issue to address 0 is ignored (no count change, no error).
- Write: on a clock edge with wr_en && wr_addr!=0: regs[wr_addr] <= wr_data. Writes are always accepted whether or not the register is pending.
- Reads: combinational, zero latency.
  - With bypass (see Optional Feature): if wr_en && wr_addr==rd_addr[k] && wr_addr!=0, rd_data[k] = wr_data.
  - Otherwise rd_data[k] = regs[rd_addr[k]].
  - Ports are independent; multiple ports may read the same address.
- Pending counter cnt[r], per register, updated at the clock edge:
  - issue only (accepted) -> cnt+1.
  - write only -> cnt-1 if cnt>0. If cnt==0: unchanged, sb_err <= 1 (plain writes such as ALU results are indicated by wr_en with an ADDR but are checked only when count tracking is used: a write to a register with cnt==0 sets sb_err only if that register has had an issue since reset; a per-register "tracked" bit is set on first issue and cleared on reset).
  - issue and write to the same register in the same cycle -> cnt unchanged.
  - issue_ready = (cnt[issue_addr] != 2**PEND_W-1). When issue_addr==0, issue_ready = 1.
  - issue_en while !issue_ready -> issue ignored, sb_err <= 1.
- rd_busy[k] = (cnt[rd_addr[k]] != 0) && rd_addr[k]!=0, except it is deasserted when the bypass is enabled, wr_en targets that address this cycle, and cnt==1.
- stall is combinational from the current inputs and state; the block has no internal stall registers.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding as above; rd_busy drops in the cycle the last pending write retires.
- Undefined: rd_data always returns stored contents; new data is visible the cycle after the write. rd_busy stays asserted through the retiring write cycle and drops one cycle later, so a consumer stalls one extra cycle.

Test Plan:
- Reset with RESET_INDEX=1 -> rd_addr=5,17 read 5 and 17; rd_addr=0 reads 0; cnt all 0, stall=0, sb_err=0.
- wr_en addr 0 data 0xDEADBEEF, issue_en addr 0 -> reg0 still reads 0; rd_busy stays 0; sb_err stays 0.
- issue r8; next cycle rd_addr0=8 with rd_use=1 -> rd_busy[0]=1, stall=1. Write r8=0x1234:
  - bypass build: same cycle rd_data=0x1234, stall=0.
  - non-bypass build: stall=1 in the write cycle, 0 next cycle, read 0x1234.
- PEND_W=2: issue r3 three times -> issue_ready=0. Fourth issue -> ignored, sb_err=1. Three writes -> cnt 0, rd_busy=0.
- Same-cycle issue and write to r9 with cnt=1 -> cnt stays 1, rd_busy[9] still 1, data updated.
- Issue r4 and r6, then assert reset one cycle -> after reset rd_busy=0 for both, reg4 reads 4, sb_err=0.
